// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// One outstanding request; imem_ack is a single-cycle completion pulse.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single outstanding imem requests,
// honours stalls/redirects and drops responses made stale by a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   StallF,
    input  logic                   PCSrcE,
    input  logic [31:0]            PCTargetE,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            InstrF,
    output logic [31:0]            PCF,
    output logic [31:0]            PCPlus4F,
    output logic                   InstrValidF
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] target;

    assign target         = PCTargetE & 32'hFFFF_FFFC;
    assign imem.imem_req  = (state == ST_WAIT) || (state == ST_DRAIN);
    assign imem.imem_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            InstrF      <= NOP_INSTR;
            PCF         <= RESET_PC;
            PCPlus4F    <= RESET_PC + 32'd4;
            InstrValidF <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    addr_q <= pc_q;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.imem_ack && !PCSrcE) begin
                        InstrF      <= imem.imem_rdata;
                        PCF         <= addr_q;
                        PCPlus4F    <= addr_q + 32'd4;
                        InstrValidF <= 1'b1;
                        pc_q        <= addr_q + 32'd4;
                        state       <= ST_HOLD;
                    end else if (imem.imem_ack) begin
                        pc_q   <= target;
                        addr_q <= target;
                    end else if (PCSrcE) begin
                        // addr_q is left alone so the abandoned request stays stable until its ack
                        pc_q  <= target;
                        state <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    if (PCSrcE) begin
                        InstrValidF <= 1'b0;
                        InstrF      <= NOP_INSTR;
                        pc_q        <= target;
                        addr_q      <= target;
                        state       <= ST_WAIT;
                    end else if (!StallF) begin
                        InstrValidF <= 1'b0;
                        InstrF      <= NOP_INSTR;
                        addr_q      <= pc_q;
                        state       <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (imem.imem_ack) begin
                        if (PCSrcE) begin
                            pc_q   <= target;
                            addr_q <= target;
                        end else begin
                            addr_q <= pc_q;
                        end
                        state <= ST_WAIT;
                    end else if (PCSrcE) begin
                        pc_q <= target;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed walkthrough of fetch, stall, redirect, wrap and reset,
// then a randomized run checked against a fetch-stream scoreboard.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] K   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    int unsigned total = 0;
    int unsigned bad   = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem       (bus),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .InstrValidF(InstrValidF)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] instr, input logic [31:0] pcf);
        chk({tag, ".req"},   {31'd0, bus.imem_req}, {31'd0, req});
        chk({tag, ".addr"},  bus.imem_addr, addr);
        chk({tag, ".valid"}, {31'd0, InstrValidF}, {31'd0, v});
        chk({tag, ".instr"}, InstrF, instr);
        chk({tag, ".pcf"},   PCF, pcf);
        chk({tag, ".pcp4"},  PCPlus4F, pcf + 32'd4);
    endtask

    task automatic mem(input logic a, input logic [31:0] d);
        bus.imem_ack   = a;
        bus.imem_rdata = d;
    endtask

    // scoreboard state for the random phase
    logic [31:0] exp_pc, addr_prev, t_prev;
    logic        v_prev, req_prev, ack_prev, p_prev, s_prev, pend;
    int unsigned lat, cnt, fetches;

    initial begin
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        mem(1'b0, '0);
        #2;
        expect_out("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        expect_out("first_req", 1'b1, 32'h0, 1'b0, NOP, 32'h0);

        // zero-wait memory: one instruction every two cycles
        for (int k = 0; k < 3; k++) begin
            mem(1'b1, (32'(k) * 4) ^ K);
            tick();
            expect_out("zw_hold", 1'b0, 32'(k) * 4, 1'b1, (32'(k) * 4) ^ K, 32'(k) * 4);
            mem(1'b0, '0);
            tick();
            expect_out("zw_wait", 1'b1, 32'(k) * 4 + 4, 1'b0, NOP, 32'(k) * 4);
        end

        // 3-cycle latency, then a 4-cycle stall in HOLD
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("lat_wait", 1'b1, 32'hC, 1'b0, NOP, 32'h8);
        end
        mem(1'b1, 32'hC ^ K);
        tick();
        expect_out("lat_hold", 1'b0, 32'hC, 1'b1, 32'hC ^ K, 32'hC);
        mem(1'b0, '0);
        StallF = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_out("stall_hold", 1'b0, 32'hC, 1'b1, 32'hC ^ K, 32'hC);
        end
        StallF = 1'b0;
        tick();
        expect_out("stall_rel", 1'b1, 32'h10, 1'b0, NOP, 32'hC);

        // redirect while 0x10 is outstanding: drain, then fetch 0x80
        tick();
        expect_out("drain_w1", 1'b1, 32'h10, 1'b0, NOP, 32'hC);
        PCSrcE = 1'b1; PCTargetE = 32'h80;
        tick();
        expect_out("drain_enter", 1'b1, 32'h10, 1'b0, NOP, 32'hC);
        PCSrcE = 1'b0;
        tick();
        expect_out("drain_hold", 1'b1, 32'h10, 1'b0, NOP, 32'hC);
        mem(1'b1, 32'hDEAD_BEEF);
        tick();
        expect_out("drain_ack", 1'b1, 32'h80, 1'b0, NOP, 32'hC);
        mem(1'b1, 32'h80 ^ K);
        tick();
        expect_out("redir_hold", 1'b0, 32'h80, 1'b1, 32'h80 ^ K, 32'h80);
        mem(1'b0, '0);
        tick();
        expect_out("redir_cons", 1'b1, 32'h84, 1'b0, NOP, 32'h80);

        // redirect coinciding with ack in WAIT; low target bits ignored
        mem(1'b1, 32'h84 ^ K);
        PCSrcE = 1'b1; PCTargetE = 32'h203;
        tick();
        expect_out("ackredir", 1'b1, 32'h200, 1'b0, NOP, 32'h80);
        PCSrcE = 1'b0;
        mem(1'b1, 32'h200 ^ K);
        tick();
        expect_out("ackredir_hold", 1'b0, 32'h200, 1'b1, 32'h200 ^ K, 32'h200);
        mem(1'b0, '0);
        tick();
        expect_out("ackredir_next", 1'b1, 32'h204, 1'b0, NOP, 32'h200);

        // redirect from HOLD (beats StallF) to the top word, then wrap
        mem(1'b1, 32'h204 ^ K);
        tick();
        expect_out("wrap_pre", 1'b0, 32'h204, 1'b1, 32'h204 ^ K, 32'h204);
        mem(1'b0, '0);
        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        tick();
        expect_out("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0, NOP, 32'h204);
        StallF = 1'b0; PCSrcE = 1'b0;
        mem(1'b1, 32'hFFFF_FFFC ^ K);
        tick();
        expect_out("wrap_hold", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC ^ K, 32'hFFFF_FFFC);
        chk("wrap_pcp4", PCPlus4F, 32'h0);
        mem(1'b0, '0);
        tick();
        expect_out("wrap_next", 1'b1, 32'h0, 1'b0, NOP, 32'hFFFF_FFFC);

        // reset during DRAIN, stale ack after release
        mem(1'b1, K);
        tick();
        expect_out("rd_hold", 1'b0, 32'h0, 1'b1, K, 32'h0);
        mem(1'b0, '0);
        tick();
        expect_out("rd_wait", 1'b1, 32'h4, 1'b0, NOP, 32'h0);
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        tick();
        expect_out("rst_drain", 1'b1, 32'h4, 1'b0, NOP, 32'h0);
        PCSrcE = 1'b0;
        #1 rst = 1'b1;
        #1;
        expect_out("rst_async", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        tick();
        rst = 1'b0;
        mem(1'b1, 32'h4 ^ K);
        tick();
        expect_out("stale_ack", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        mem(1'b1, K);
        tick();
        expect_out("restart", 1'b0, 32'h0, 1'b1, K, 32'h0);
        mem(1'b0, '0);

        // randomized run against the fetch-stream scoreboard
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc = 32'h0; pend = 1'b0; fetches = 0; lat = 0; cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.imem_req) begin
                if (!pend) begin
                    pend = 1'b1;
                    lat  = $urandom_range(0, 3);
                    cnt  = 0;
                end
                if (cnt == lat) begin
                    mem(1'b1, bus.imem_addr ^ K);
                    pend = 1'b0;
                end else begin
                    mem(1'b0, $urandom);
                    cnt++;
                end
            end else begin
                pend = 1'b0;
                mem($urandom_range(0, 7) == 0, $urandom);
            end
            StallF    = ($urandom_range(0, 2) == 0);
            PCSrcE    = (c > 0) && ($urandom_range(0, 9) == 0);
            PCTargetE = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                     : 32'($urandom_range(0, 1023));
            v_prev = InstrValidF; req_prev = bus.imem_req; addr_prev = bus.imem_addr;
            ack_prev = bus.imem_ack; p_prev = PCSrcE; t_prev = PCTargetE; s_prev = StallF;
            tick();

            if (p_prev)
                exp_pc = t_prev & 32'hFFFF_FFFC;
            else if (v_prev && !s_prev)
                exp_pc = exp_pc + 32'd4;

            if (InstrValidF && !v_prev) begin
                fetches++;
                chk("rnd_pcf",   PCF, exp_pc);
                chk("rnd_instr", InstrF, exp_pc ^ K);
                chk("rnd_pcp4",  PCPlus4F, exp_pc + 32'd4);
            end
            if (req_prev && !ack_prev) begin
                chk("rnd_req_stable",  {31'd0, bus.imem_req}, 32'd1);
                chk("rnd_addr_stable", bus.imem_addr, addr_prev);
            end
            chk("rnd_excl", {31'd0, bus.imem_req & InstrValidF}, 32'd0);
            if (!InstrValidF)
                chk("rnd_bubble", InstrF, NOP);
        end
        chk("rnd_progress", {31'd0, fetches >= 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage controller. It owns the fetch PC, issues one outstanding request at a time to instruction memory over a req/ack handshake, and presents registered InstrF/PCF/PCPlus4F to the IF/ID pipeline register. It honours hazard-unit stalls and redirects from the execute stage (taken branch, jal, jalr), and discards any in-flight response made stale by a redirect. When it has no valid instruction, it emits a NOP so decode receives a bubble without extra clearing logic.

## Interface
- RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 00
- NOP_INSTR, 32'h00000013, instruction driven when no valid instruction is held (addi x0,x0,0)

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- StallF  in  1  hazard-unit stall; 1 = IF/ID will not capture this cycle
- PCSrcE  in  1  redirect request from execute stage
- PCTargetE  in  32  redirect target; bits [1:0] ignored (forced 00)
- imem_req  out  1  memory request, Moore output of FSM
- imem_addr  out  32  request address, from register addr_q, stable while imem_req=1
- imem_ack  in  1  one-cycle completion pulse; may arrive in the same cycle imem_req first rises
- imem_rdata  in  32  instruction word, valid only when imem_ack=1
- InstrF  out  32  registered instruction to IF/ID
- PCF  out  32  address of InstrF
- PCPlus4F  out  32  PCF+4
- InstrValidF  out  1  1 = InstrF/PCF are a real fetched instruction

## Operation
- Internal registers:
  - pc_q: next address to fetch.
  - addr_q: address of the outstanding request.
  - Output registers.
  - FSM with states IDLE, WAIT, HOLD, DRAIN.
- Consumption: the held instruction is consumed at a rising edge where InstrValidF=1 and StallF=0.
- IDLE (reset state): imem_req=0. Next state is WAIT, with addr_q<=pc_q.
- WAIT: imem_req=1, InstrValidF=0.
  - ack and no PCSrcE: InstrF<=rdata, PCF<=addr_q, PCPlus4F<=addr_q+4, InstrValidF<=1, pc_q<=addr_q+4; go to HOLD.
  - ack and PCSrcE: discard rdata; pc_q<=target and addr_q<=target; stay in WAIT (new request starts next cycle).
  - PCSrcE without ack: pc_q<=target; go to DRAIN. addr_q is unchanged, so the old request stays stable.
  - Otherwise: hold.
- HOLD: imem_req=0, InstrValidF=1.
  - PCSrcE: InstrValidF<=0, InstrF<=NOP_INSTR, pc_q<=target, addr_q<=target; go to WAIT. A redirect takes priority over StallF.
  - StallF=0 (consumed): InstrValidF<=0, InstrF<=NOP_INSTR, addr_q<=pc_q; go to WAIT.
  - StallF=1: hold every output.
- DRAIN: imem_req=1 with the stale addr_q; InstrValidF=0.
  - ack: discard rdata; addr_q<=pc_q, or the target if PCSrcE is asserted in the same cycle; go to WAIT.
  - PCSrcE without ack: pc_q<=target; stay in DRAIN.
- Arithmetic: all +4 operations are modulo 2^32, so 32'hFFFFFFFC+4 = 32'h00000000.
- imem_ack outside WAIT/DRAIN is ignored.
- StallF is ignored in WAIT and DRAIN, because the outputs already show a NOP bubble.

## Timing
- Reset values (applied asynchronously, held while rst=1):
  - state=IDLE, pc_q=addr_q=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - InstrF=NOP_INSTR, PCF=RESET_PC, PCPlus4F=RESET_PC+4, InstrValidF=0
- First request: imem_req rises in the 2nd cycle after rst deasserts (the IDLE cycle comes first).
- Latency: InstrValidF rises one edge after the ack edge. With zero-wait memory (ack in the first req cycle), sustained throughput is one instruction per 2 cycles: WAIT, then HOLD.
- Handshake: imem_req and imem_addr are stable from request start until and including the ack cycle. imem_req may stay high into the next request with a new address.
- rst mid-transaction: imem_req drops immediately. Memory must abandon the transaction, and any later ack is ignored.
- Redirect effect: after PCSrcE, InstrValidF is 0 from the next edge until the target's ack.

## Test plan
- Reset, RESET_PC=0, memory acks with zero wait and data = address ^ 32'hA5A50000, StallF=0 -> fetches PCF=0,4,8 on alternate cycles with InstrF=32'hA5A50000,32'hA5A50004,…; InstrValidF toggles 1/0.
- 3-cycle memory latency plus StallF=1 for 4 cycles while in HOLD -> InstrF/PCF frozen; no new imem_req until StallF falls; next imem_addr=PCF+4.
- Ack for 0x10 delayed 3 cycles, PCSrcE=1 with PCTargetE=0x80 on the 2nd wait cycle -> imem_addr stays 0x10 until ack; rdata discarded, InstrValidF stays 0; next imem_addr=0x80; first valid PCF=0x80.
- PCSrcE=1 with PCTargetE=0x203 in the same cycle as ack in WAIT -> data dropped; next request imem_addr=0x200; PCPlus4F later=0x204.
- Redirect to 0xFFFFFFFC -> PCF=0xFFFFFFFC, PCPlus4F=0x00000000, next imem_addr=0x00000000.
- rst pulse during DRAIN with a late ack arriving after release -> outputs return to reset values immediately; the stale ack is ignored; fetch restarts at RESET_PC.
